// File: rtl/seq_divider_pkg.sv
// Shared ALU types and helpers for the sequential divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } div_state_t;

  localparam int unsigned BITS_DEFAULT = 4;

  // Step counter must hold the value BITS.
  function automatic int unsigned ctr_width(input int unsigned bits);
    return $clog2(bits + 1);
  endfunction

  localparam int unsigned CTR_W_DEFAULT = ctr_width(BITS_DEFAULT);

endpackage

// File: rtl/adder_substractor.sv
// ALU adder/subtractor: select_i=0 adds, select_i=1 subtracts (two's complement).
module adder_substractor #(
  parameter int unsigned BITS = 4
) (
  input  logic [BITS-1:0] a_i,
  input  logic [BITS-1:0] b_i,
  input  logic            select_i,
  output logic [BITS-1:0] result_o,
  output logic            flag_v_o
);

  logic [BITS-1:0] b_eff;

  assign b_eff    = b_i ^ {BITS{select_i}};
  assign result_o = a_i + b_eff + BITS'(select_i);

  // Signed overflow: operands agree in sign, result does not.
  assign flag_v_o = (a_i[BITS-1] == b_eff[BITS-1]) &&
                    (result_o[BITS-1] != a_i[BITS-1]);

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned BITS = BITS_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [BITS-1:0] dividend_i,
  input  logic [BITS-1:0] divisor_i,
  output logic [BITS-1:0] quotient_o,
  output logic [BITS-1:0] remainder_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            flag_dz_o
);

  localparam int unsigned CNT_W = ctr_width(BITS);
  localparam int unsigned RW    = BITS + 1;

  div_state_t       state;
  div_state_t       state_nx;
  logic [BITS-1:0]  q;
  logic [BITS-1:0]  d;
  logic [RW-1:0]    r;
  logic [CNT_W-1:0] cnt;
  logic             dz;

  logic             accept;
  logic             zero_div;
  logic             last_step;
  logic [RW-1:0]    s;
  logic [RW-1:0]    t;
  logic             flag_v;
  logic [1:0]       unused_bits;

  assign accept    = start_i && (state != DIVIDE);
  assign zero_div  = (divisor_i == '0);
  assign last_step = (cnt == CNT_W'(1));

  // Shift the next dividend bit into the partial remainder, then trial-subtract D.
  assign s = {r[BITS-1:0], q[BITS-1]};

  adder_substractor #(
    .BITS(RW)
  ) u_sub (
    .a_i      (s),
    .b_i      ({1'b0, d}),
    .select_i (1'b1),
    .result_o (t),
    .flag_v_o (flag_v)
  );

  // Overflow is meaningless for unsigned division; R's top bit is always zero once stored.
  assign unused_bits = {flag_v, r[BITS]};

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      DIVIDE: if (last_step) state_nx = DONE;
      default: begin
        if (accept) state_nx = zero_div ? DONE : DIVIDE;
        else        state_nx = IDLE;
      end
    endcase
  end

  // Status outputs decoded from state only
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state)
      DIVIDE:  busy_o = 1'b1;
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture and one restoring step per DIVIDE cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q   <= '0;
      r   <= '0;
      d   <= '0;
      cnt <= '0;
      dz  <= 1'b0;
    end else if (state == DIVIDE) begin
      if (!t[BITS]) begin
        r <= t;
        q <= {q[BITS-2:0], 1'b1};
      end else begin
        r <= s;
        q <= {q[BITS-2:0], 1'b0};
      end
      cnt <= cnt - CNT_W'(1);
    end else if (accept) begin
      if (zero_div) begin
        q  <= '1;
        r  <= {1'b0, dividend_i};
        dz <= 1'b1;
      end else begin
        d   <= divisor_i;
        q   <= dividend_i;
        r   <= '0;
        cnt <= CNT_W'(BITS);
        dz  <= 1'b0;
      end
    end
  end

  assign quotient_o  = q;
  assign remainder_o = r[BITS-1:0];
  assign flag_dz_o   = dz;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (BITS=4): driver pushes expectations, monitor checks on done_o.
module tb_seq_divider;

  localparam int unsigned BITS = 4;

  typedef struct {
    logic [BITS-1:0] q;
    logic [BITS-1:0] r;
    logic            dz;
    int              busy;
  } exp_t;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            start_i = 1'b0;
  logic [BITS-1:0] dividend_i = '0;
  logic [BITS-1:0] divisor_i = '0;
  logic [BITS-1:0] quotient_o;
  logic [BITS-1:0] remainder_o;
  logic            busy_o;
  logic            done_o;
  logic            flag_dz_o;

  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  exp_t exp_q[$];

  seq_divider #(.BITS(BITS)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .flag_dz_o   (flag_dz_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q = 4'hF; e.r = 4'(a); e.dz = 1'b1; e.busy = 0;
    end else begin
      e.q = 4'(a / b); e.r = 4'(a % b); e.dz = 1'b0; e.busy = BITS;
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: compare every presented result against the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_i) begin
      busy_cnt = 0;
    end else begin
      check("busy_done_exclusive", int'(busy_o && done_o), 0);
      if (busy_o) busy_cnt++;
      if (done_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("quotient", int'(quotient_o), int'(e.q));
          check("remainder", int'(remainder_o), int'(e.r));
          check("flag_dz", int'(flag_dz_o), int'(e.dz));
          check("busy_cycles", busy_cnt, e.busy);
        end
        busy_cnt = 0;
      end
    end
  end

  // Issue one request: accepted at the next rising edge; returns 1ns after it.
  task automatic start_op(input int a, input int b);
    dividend_i = 4'(a);
    divisor_i  = 4'(b);
    start_i    = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    #3;
    check("rst_quotient", int'(quotient_o), 0);
    check("rst_remainder", int'(remainder_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_flag_dz", int'(flag_dz_o), 0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    idle_cycles(1);

    // Directed cases
    start_op(13, 3); wait_done(); idle_cycles(1);
    start_op(15, 1); wait_done(); idle_cycles(1);
    start_op(3, 7);  wait_done(); idle_cycles(1);
    start_op(5, 0);  wait_done(); idle_cycles(1);
    start_op(6, 2);  wait_done(); idle_cycles(1);

    // Start during DIVIDE must be ignored
    start_op(9, 2);
    idle_cycles(1);
    dividend_i = 4'd15; divisor_i = 4'd5; start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    wait_done(); idle_cycles(1);

    // Async reset mid-DIVIDE between edges 2 and 3
    start_op(12, 5);
    idle_cycles(2);
    #1 rst_i = 1'b1;
    #1;
    check("abort_quotient", int'(quotient_o), 0);
    check("abort_remainder", int'(remainder_o), 0);
    check("abort_busy", int'(busy_o), 0);
    check("abort_done", int'(done_o), 0);
    exp_q.delete();
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    idle_cycles(1);
    start_op(12, 5); wait_done(); idle_cycles(1);

    // Back-to-back: start held high into the DONE cycle
    dividend_i = 4'd6; divisor_i = 4'd3; start_i = 1'b1;
    exp_q.push_back(model(6, 3));
    wait_done();
    dividend_i = 4'd14; divisor_i = 4'd4;
    exp_q.push_back(model(14, 4));
    @(posedge clk_i);
    #1 start_i = 1'b0;
    wait_done(); idle_cycles(1);

    // Exhaustive sweep with random gaps
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        start_op(a, b);
        wait_done();
        idle_cycles(int'($urandom_range(0, 3)));
      end
    end

    idle_cycles(3);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
